// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// with a memory-ready handshake, wait timeout, illegal-opcode trap and retire counter.
module multicycle_control_unit #(
  parameter int unsigned OPCODE_W    = 6,
  parameter int unsigned ALUOP_W     = 3,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned ENABLE_SLTI = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [OPCODE_W-1:0] opcode_i,
  input  logic                mem_ready_i,
  output logic                pc_write_o,
  output logic                pc_write_cond_o,
  output logic                pc_source_o,
  output logic                ir_write_o,
  output logic                iord_o,
  output logic                mem_read_o,
  output logic                mem_write_o,
  output logic                mem_to_reg_o,
  output logic                reg_dst_o,
  output logic                reg_write_o,
  output logic                alu_src_a_o,
  output logic [1:0]          alu_src_b_o,
  output logic [ALUOP_W-1:0]  alu_op_o,
  output logic [3:0]          state_o,
  output logic                instr_done_o,
  output logic                err_o,
  output logic [CNT_W-1:0]    retired_o
);

  localparam int unsigned WaitW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WaitW-1:0] WaitLimit = WaitW'(MEM_TIMEOUT);

  localparam logic [OPCODE_W-1:0] OpRtype = '0;
  localparam logic [OPCODE_W-1:0] OpLw    = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OpSw    = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OpBeq   = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OpAddi  = OPCODE_W'(7);

  localparam logic [ALUOP_W-1:0] AluFunct = '0;
  localparam logic [ALUOP_W-1:0] AluSub   = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] AluSlt   = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] AluAdd   = ALUOP_W'(3);

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAddr = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StExecR   = 4'd6,
    StRWb     = 4'd7,
    StBranch  = 4'd8,
    StExecI   = 4'd9,
    StIWb     = 4'd10,
    StError   = 4'd15
  } state_e;

  state_e              state_q, state_d;
  logic [OPCODE_W-1:0] opq_q, opq_d;
  logic [WaitW-1:0]    wait_q, wait_d;
  logic [CNT_W-1:0]    retired_q, retired_d;
  logic                wait_state;
  logic                timed_out;
  logic                instr_done;

  assign wait_state = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
  // A ready on the limit cycle still completes the access.
  assign timed_out  = (MEM_TIMEOUT != 0) && !mem_ready_i && (wait_q == WaitLimit);

  always_comb begin
    state_d = state_q;
    opq_d   = opq_q;
    case (state_q)
      StFetch: begin
        if (mem_ready_i)    state_d = StDecode;
        else if (timed_out) state_d = StError;
      end
      StDecode: begin
        opq_d = opcode_i;
        if (opcode_i == OpRtype)                        state_d = StExecR;
        else if ((opcode_i == OpLw) || (opcode_i == OpSw)) state_d = StMemAddr;
        else if (opcode_i == OpBeq)                     state_d = StBranch;
        else if (opcode_i == OpAddi)                    state_d = StExecI;
        else if (ENABLE_SLTI != 0)                      state_d = StExecI;
        else                                            state_d = StError;
      end
      StMemAddr: state_d = (opq_q == OpLw) ? StMemRd : StMemWr;
      StMemRd: begin
        if (mem_ready_i)    state_d = StMemWb;
        else if (timed_out) state_d = StError;
      end
      StMemWb: state_d = StFetch;
      StMemWr: begin
        if (mem_ready_i)    state_d = StFetch;
        else if (timed_out) state_d = StError;
      end
      StExecR:  state_d = StRWb;
      StRWb:    state_d = StFetch;
      StBranch: state_d = StFetch;
      StExecI:  state_d = StIWb;
      StIWb:    state_d = StFetch;
      StError:  state_d = StError;
      default:  state_d = StFetch;
    endcase
  end

  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (wait_state && !mem_ready_i && (wait_q != WaitLimit)) begin
      wait_d = wait_q + WaitW'(1);
    end
  end

  assign instr_done = (state_q == StMemWb) || (state_q == StRWb) || (state_q == StBranch) ||
                      (state_q == StIWb) || ((state_q == StMemWr) && mem_ready_i);

  always_comb begin
    retired_d = retired_q;
    if (instr_done) retired_d = retired_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StFetch;
      opq_q     <= '0;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      opq_q     <= opq_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    pc_source_o     = 1'b0;
    ir_write_o      = 1'b0;
    iord_o          = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    mem_to_reg_o    = 1'b0;
    reg_dst_o       = 1'b0;
    reg_write_o     = 1'b0;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = 2'b00;
    alu_op_o        = AluFunct;
    case (state_q)
      StFetch: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = 2'b01;
        alu_op_o    = AluAdd;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
      end
      StDecode: begin
        alu_src_b_o = 2'b11;
        alu_op_o    = AluAdd;
      end
      StMemAddr: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        alu_op_o    = AluAdd;
      end
      StMemRd: begin
        mem_read_o = 1'b1;
        iord_o     = 1'b1;
      end
      StMemWb: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
      end
      StMemWr: begin
        mem_write_o = 1'b1;
        iord_o      = 1'b1;
      end
      StExecR: alu_src_a_o = 1'b1;
      StRWb: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
      end
      StBranch: begin
        alu_src_a_o     = 1'b1;
        alu_op_o        = AluSub;
        pc_write_cond_o = 1'b1;
        pc_source_o     = 1'b1;
      end
      StExecI: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        alu_op_o    = (opq_q == OpAddi) ? AluAdd : AluSlt;
      end
      StIWb: reg_write_o = 1'b1;
      default: ;
    endcase
  end

  assign state_o      = state_q;
  assign instr_done_o = instr_done;
  assign err_o        = (state_q == StError);
  assign retired_o    = retired_q;

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle successor to the single-cycle opcode decoder in the MIPS CPU.
- A registered FSM sequences fetch, decode, execute, memory and writeback over several cycles, and drives one shared ALU and one unified memory.
- Adds a memory-ready handshake, a wait timeout, an illegal-opcode trap and a retired-instruction counter.
- Sits between the instruction register and the multi-cycle datapath.

Parameters:
- OPCODE_W, 6: opcode width. Opcode encodings below are given for 6 bits and zero-extended if wider.
- ALUOP_W, 3: aluOp width, minimum 3.
- MEM_TIMEOUT, 15: maximum consecutive cycles waiting on memReady before entering ERROR. 0 disables the timeout.
- ENABLE_SLTI, 1: 1 decodes unlisted opcodes as slti; 0 traps them to ERROR.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock, the only clock.
- rst  in  1  synchronous, active-high reset.
- opcode  in  OPCODE_W  instruction register [31:26]. Valid from DECODE onward.
- memReady  in  1  memory completes the current access this cycle.
- pcWrite  out  1  unconditional PC load.
- pcWriteCond  out  1  PC load if ALU zero.
- pcSource  out  1  0 = ALU result, 1 = ALUOut (branch target).
- irWrite  out  1  load the instruction register.
- iorD  out  1  0 = PC address, 1 = ALUOut address.
- memRead  out  1  memory read strobe.
- memWrite  out  1  memory write strobe.
- memToReg  out  1  writeback data from MDR.
- regDst  out  1  1 = rd, 0 = rt.
- regWrite  out  1  register file write.
- aluSrcA  out  1  0 = PC, 1 = rs.
- aluSrcB  out  2  00 = rt, 01 = 4, 10 = sign-extended immediate, 11 = immediate shifted left 2.
- aluOp  out  ALUOP_W  000 = R-type funct, 011 = add, 001 = sub, 010 = slt.
- state  out  4  current state, for debug.
- instrDone  out  1  one-cycle pulse on the last cycle of an instruction.
- err  out  1  sticky; set in ERROR.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Reset: state = FETCH (0). retired = 0, err = 0, wait counter = 0, opQ = 0. All strobes follow the FETCH decode.
- Encodings: FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_RD = 3, MEM_WB = 4, MEM_WR = 5, EXEC_R = 6, R_WB = 7, BRANCH = 8, EXEC_I = 9, I_WB = 10, ERROR = 15.
- Outputs are decoded from the state register. Exceptions: irWrite and pcWrite in FETCH are qualified by memReady.
- Any strobe not listed for a state is 0.
- FETCH:
  - memRead = 1, iorD = 0, aluSrcA = 0, aluSrcB = 01, aluOp = 011, pcSource = 0.
  - irWrite = pcWrite = memReady.
  - Go to DECODE when memReady is 1; otherwise stay.
- DECODE:
  - aluSrcA = 0, aluSrcB = 11, aluOp = 011.
  - Latch opcode into opQ.
  - Next state: 000000 -> EXEC_R; 000100 (lw) or 000101 (sw) -> MEM_ADDR; 000110 (beq) -> BRANCH; 000111 (addi) -> EXEC_I.
  - Any other opcode -> EXEC_I if ENABLE_SLTI = 1, else ERROR.
- MEM_ADDR: aluSrcA = 1, aluSrcB = 10, aluOp = 011. Next state is MEM_RD if opQ is lw, else MEM_WR.
- MEM_RD: memRead = 1, iorD = 1. Stay until memReady, then go to MEM_WB.
- MEM_WB: regWrite = 1, memToReg = 1, regDst = 0. Go to FETCH.
- MEM_WR: memWrite = 1, iorD = 1. Stay until memReady, then go to FETCH.
- EXEC_R: aluSrcA = 1, aluSrcB = 00, aluOp = 000. Go to R_WB.
- R_WB: regWrite = 1, regDst = 1. Go to FETCH.
- BRANCH: aluSrcA = 1, aluSrcB = 00, aluOp = 001, pcWriteCond = 1, pcSource = 1. Go to FETCH.
- EXEC_I: aluSrcA = 1, aluSrcB = 10. aluOp = 011 if opQ is addi, else 010. Go to I_WB.
- I_WB: regWrite = 1, regDst = 0. Go to FETCH.
- ERROR: all strobes 0, err = 1. Exits only on rst.
- instrDone pulses (1 cycle):
  - in MEM_WB, R_WB, BRANCH and I_WB;
  - in MEM_WR on the cycle memReady = 1.
  - retired increments on the same edge, wrapping modulo 2^CNT_W.
- Timeout:
  - The wait counter clears on entry to FETCH, MEM_RD or MEM_WR.
  - It increments each cycle in those states while memReady = 0.
  - When the count reaches MEM_TIMEOUT with memReady still 0, the next state is ERROR.
  - memReady = 1 on the same cycle as the limit wins; the access completes normally.
- rst mid-instruction: the next state is FETCH, and any pending access is abandoned.
- Strobes are combinational from state, so no strobe is asserted on the cycle after rst deasserts except the FETCH set.

Test Plan:
- rst high 2 cycles, then memReady = 1 constantly, lw (000100) -> states 0, 1, 2, 3, 4. instrDone in state 4, retired = 1, 5 cycles total.
- memReady = 1, sequence R-type, sw, beq, addi -> 4, 4, 3 and 4 cycles. EXEC_R aluOp = 000, BRANCH aluOp = 001 with pcWriteCond = 1. retired = 4.
- slti (001010), ENABLE_SLTI = 1 -> EXEC_I aluOp = 010. With ENABLE_SLTI = 0 -> state 15, err = 1, holds until rst.
- MEM_RD with memReady low for 3 cycles -> stays in state 3 with memRead = iorD = 1, exits to MEM_WB on the cycle after memReady rises.
- MEM_TIMEOUT = 15, memReady held 0 in FETCH -> ERROR after the 15-cycle limit. Repeat with memReady = 1 on the limit cycle -> DECODE, err = 0.
- rst asserted in MEM_WR -> next cycle state = 0, memWrite = 0, retired unchanged.
